// File: rtl/pkt_capture_pkg.sv
// pkt_capture_pkg: shared state encoding, path limits and packet-length decode for the capture sequencer.
package pkt_capture_pkg;
  typedef enum logic [1:0] {IDLE, CAPT, GAP, DONE} cap_state_e;
  localparam int PATHS_FULL = 96;
  localparam int PATHS_HALF = 48;
  function automatic logic [9:0] pkt_len(input logic [1:0] code);
    return 10'd64 << code;
  endfunction
endpackage

// File: rtl/rise_edge_det.sv
// rise_edge_det: registered rising-edge detector, pulse is combinational in the cycle the input rises.
module rise_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);
  logic d_q;
  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else d_q <= d_i;
  end
  assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/pkt_capture_seq.sv
// pkt_capture_seq: writes framed packet bursts of ADC samples into the capture RAM with idle gaps between packets.
module pkt_capture_seq
  import pkt_capture_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 9,
  parameter int PATH_W    = 7,
  parameter int MAX_PATHS = PATHS_FULL
) (
  input  logic              pktctrl_clk,
  input  logic              pktctrl_rst,
  input  logic              rf_capture_mode_sync,
  input  logic              rf_capture_start_sync,
  input  logic              rf_capture_again_sync,
  input  logic              rf_self_test_mode_sync,
  input  logic              rf_96path_en_sync,
  input  logic [1:0]        rf_pkt_data_length_sync,
  input  logic [15:0]       rf_pkt_idle_length_sync,
  input  logic              adc_valid,
  input  logic [PATH_W-1:0] adc_path,
  input  logic [DATA_W-1:0] adc_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              capture_busy,
  output logic              capture_done,
  output logic [9:0]        pkt_cnt
);
  localparam int HALF_PATHS = MAX_PATHS * PATHS_HALF / PATHS_FULL;
  cap_state_e        state_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [8:0]        word_q;
  logic [15:0]       idle_q;
  logic [9:0]        len_q;
  logic [15:0]       gap_q;
  logic [9:0]        pkt_cnt_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_waddr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              start_rise, again_rise, acc, cap_acc, pkt_end;
  rise_edge_det u_start (
    .clk(pktctrl_clk), .rst(pktctrl_rst), .d_i(rf_capture_start_sync), .rise_o(start_rise)
  );
  rise_edge_det u_again (
    .clk(pktctrl_clk), .rst(pktctrl_rst), .d_i(rf_capture_again_sync), .rise_o(again_rise)
  );
  always_comb begin
    acc     = rf_self_test_mode_sync ? 1'b1 :
              adc_valid & (32'(adc_path) < (rf_96path_en_sync ? MAX_PATHS : HALF_PATHS));
    cap_acc = (state_q == CAPT) & acc;
    pkt_end = {1'b0, word_q} == len_q - 10'd1;
  end
  always_ff @(posedge pktctrl_clk) begin
    if (pktctrl_rst) begin
      state_q     <= IDLE;
      waddr_q     <= '0;
      word_q      <= '0;
      idle_q      <= '0;
      len_q       <= '0;
      gap_q       <= '0;
      pkt_cnt_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      // An accepted sample is registered even in an abort cycle
      mem_we_q <= cap_acc;
      if (cap_acc) begin
        mem_waddr_q <= waddr_q;
        mem_wdata_q <= rf_self_test_mode_sync ? DATA_W'(waddr_q) : adc_data;
      end
      if (state_q != IDLE && !rf_capture_start_sync) state_q <= IDLE;
      else begin
        case (state_q)
          IDLE, DONE: begin
            if ((state_q == IDLE) ? start_rise : again_rise) begin
              state_q   <= CAPT;
              waddr_q   <= '0;
              word_q    <= '0;
              pkt_cnt_q <= '0;
              len_q     <= pkt_len(rf_pkt_data_length_sync);
              gap_q     <= rf_pkt_idle_length_sync;
            end
          end
          CAPT: begin
            if (acc) begin
              waddr_q <= waddr_q + 1'b1;
              word_q  <= pkt_end ? 9'd0 : word_q + 9'd1;
              if (pkt_end) begin
                pkt_cnt_q <= pkt_cnt_q + 10'd1;
                if (&waddr_q && !rf_capture_mode_sync) state_q <= DONE;
                else if (gap_q != 16'd0) begin
                  state_q <= GAP;
                  idle_q  <= gap_q;
                end
              end
            end
          end
          GAP: begin
            idle_q <= idle_q - 16'd1;
            if (idle_q == 16'd1) state_q <= CAPT;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign mem_we       = mem_we_q;
  assign mem_waddr    = mem_waddr_q;
  assign mem_wdata    = mem_wdata_q;
  assign capture_busy = (state_q == CAPT) | (state_q == GAP);
  assign capture_done = state_q == DONE;
  assign pkt_cnt      = pkt_cnt_q;
endmodule

// File: tb/tb_pkt_capture_seq.sv
// tb_pkt_capture_seq: directed scenario tests for the capture sequencer with hand-derived expectations.
module tb_pkt_capture_seq;
  logic clk = 1'b0, rst = 1'b1;
  logic mode, start, again, st, en, valid;
  logic [1:0] code;
  logic [15:0] idl;
  logic [6:0] path;
  logic [8:0] data;
  logic we, busy, done;
  logic [14:0] waddr;
  logic [8:0] wdata;
  logic [9:0] pcnt;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  pkt_capture_seq dut (
    .pktctrl_clk(clk), .pktctrl_rst(rst),
    .rf_capture_mode_sync(mode), .rf_capture_start_sync(start), .rf_capture_again_sync(again),
    .rf_self_test_mode_sync(st), .rf_96path_en_sync(en),
    .rf_pkt_data_length_sync(code), .rf_pkt_idle_length_sync(idl),
    .adc_valid(valid), .adc_path(path), .adc_data(data),
    .mem_we(we), .mem_waddr(waddr), .mem_wdata(wdata),
    .capture_busy(busy), .capture_done(done), .pkt_cnt(pcnt)
  );
  task automatic do_reset;
    rst = 1'b1; start = 0; again = 0; valid = 0; st = 0; en = 1; mode = 0;
    code = 0; idl = 0; path = 0; data = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic wait_we(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!we && n < 20);
    total++;
    if (we !== 1'b1) begin $display("FAIL %s: mem_we=%b after %0d cycles, required 1", nm, we, n); bad++; end
  endtask
  task automatic test_reset;
    do_reset;
    total++;
    if ({we, waddr, wdata, busy, done, pcnt} !== '0)
      begin $display("FAIL reset_outputs: we=%b waddr=%0d wdata=%0d busy=%b done=%b pkt=%0d, required all 0", we, waddr, wdata, busy, done, pcnt); bad++; end
  endtask
  task automatic test_single_selftest_and_again;
    int e = 0;
    do_reset;
    code = 0; st = 1; data = 9'h0AA; start = 1;
    wait_we("single_first_we");
    for (int i = 0; i < 32768; i++) begin
      if (e == 0 && (we !== 1'b1 || waddr !== 15'(i) || wdata !== 9'(i))) begin
        $display("FAIL single_stream: i=%0d we=%b waddr=%0d wdata=%0d, required we=1 waddr=%0d wdata=%0d", i, we, waddr, wdata, i, 9'(i));
        e = 1;
      end
      if (i < 32767) @(negedge clk);
    end
    total++; bad += e;
    total++;
    if (done !== 1'b1 || pcnt !== 10'd512) begin $display("FAIL single_done: done=%b pkt=%0d, required 1/512", done, pcnt); bad++; end
    @(negedge clk);
    total++;
    if (we !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin $display("FAIL single_hold: we=%b done=%b busy=%b, required 0/1/0", we, done, busy); bad++; end
    code = 1; again = 1;
    wait_we("again_first_we");
    total++;
    if (waddr !== 15'd0 || done !== 1'b0) begin $display("FAIL again_restart: waddr=%0d done=%b, required 0/0", waddr, done); bad++; end
    repeat (63) @(negedge clk);
    total++;
    if (waddr !== 15'd63 || pcnt !== 10'd0) begin $display("FAIL again_newlen_mid: waddr=%0d pkt=%0d, required 63/0", waddr, pcnt); bad++; end
    repeat (64) @(negedge clk);
    total++;
    if (waddr !== 15'd127 || pcnt !== 10'd1) begin $display("FAIL again_newlen_end: waddr=%0d pkt=%0d, required 127/1", waddr, pcnt); bad++; end
    start = 0;
    repeat (2) @(negedge clk);
    again = 0;
    @(negedge clk);
    again = 1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || we !== 1'b0 || done !== 1'b0) begin $display("FAIL again_start_low: busy=%b we=%b done=%b, required 0/0/0", busy, we, done); bad++; end
    again = 0;
  endtask
  task automatic test_gap;
    int e = 0;
    do_reset;
    mode = 1; code = 1; idl = 5; valid = 1; data = 9'h1A5; start = 1;
    wait_we("gap_first_we");
    for (int i = 0; i < 128; i++) begin
      if (e == 0 && (we !== 1'b1 || waddr !== 15'(i))) begin
        $display("FAIL gap_packet: i=%0d we=%b waddr=%0d, required 1/%0d", i, we, waddr, i); e = 1;
      end
      if (i < 127) begin @(negedge clk); path = (path == 7'd47) ? 7'd0 : path + 7'd1; end
    end
    total++; bad += e;
    total++;
    if (pcnt !== 10'd1 || wdata !== 9'h1A5) begin $display("FAIL gap_pkt_cnt: pkt=%0d wdata=%h, required 1/1a5", pcnt, wdata); bad++; end
    e = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (e == 0 && (we !== 1'b0 || busy !== 1'b1)) begin $display("FAIL gap_idle: k=%0d we=%b busy=%b, required 0/1", k, we, busy); e = 1; end
    end
    total++; bad += e;
    @(negedge clk);
    total++;
    if (we !== 1'b1 || waddr !== 15'd128) begin $display("FAIL gap_resume: we=%b waddr=%0d, required 1/128", we, waddr); bad++; end
  endtask
  task automatic test_paths;
    logic [8:0] q[$];
    logic [8:0] exp;
    int e = 0, nw = 0;
    do_reset;
    en = 0; mode = 1; code = 3; start = 1;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin $display("FAIL paths_busy: busy=%b, required 1", busy); bad++; end
    for (int i = 0; i <= 192; i++) begin
      if (we) begin
        exp = (q.size() > 0) ? q.pop_front() : 9'h1FF;
        if (e == 0 && (waddr !== 15'(nw) || wdata !== exp)) begin
          $display("FAIL paths_half_write: waddr=%0d wdata=%0d, required %0d/%0d", waddr, wdata, nw, exp); e = 1;
        end
        nw++;
      end
      if (i < 192) begin
        valid = 1; path = 7'(i % 96); data = 9'(i);
        if (i % 96 < 48) q.push_back(9'(i));
      end else valid = 0;
      @(negedge clk);
    end
    total++; bad += e;
    total++;
    if (nw != 96) begin $display("FAIL paths_half_count: writes=%0d, required 96", nw); bad++; end
    en = 1; e = 0;
    for (int i = 0; i < 32; i++) begin
      if (we !== 1'b0) e = 1;
      valid = 1; path = 7'(96 + i); data = 9'h155;
      @(negedge clk);
    end
    if (we !== 1'b0) e = 1;
    total++;
    if (e != 0) begin $display("FAIL paths_high_drop: write seen for path>=96, required none"); bad++; end
    path = 7'd10; data = 9'h055;
    @(negedge clk);
    valid = 0;
    total++;
    if (we !== 1'b1 || waddr !== 15'd96 || wdata !== 9'h055) begin $display("FAIL paths_full_accept: we=%b waddr=%0d wdata=%h, required 1/96/055", we, waddr, wdata); bad++; end
  endtask
  task automatic test_wrap;
    int n = 0;
    do_reset;
    mode = 1; code = 3; st = 1; start = 1;
    wait_we("wrap_first_we");
    while (!(we && waddr == 15'h7FFF) && n < 40000) begin @(negedge clk); n++; end
    total++;
    if (we !== 1'b1 || waddr !== 15'h7FFF) begin $display("FAIL wrap_reach_top: we=%b waddr=%0d, required 1/32767", we, waddr); bad++; end
    total++;
    if (pcnt !== 10'd64 || wdata !== 9'h1FF) begin $display("FAIL wrap_top_cnt: pkt=%0d wdata=%h, required 64/1ff", pcnt, wdata); bad++; end
    @(negedge clk);
    total++;
    if (we !== 1'b1 || waddr !== 15'd0 || done !== 1'b0) begin $display("FAIL wrap_to_zero: we=%b waddr=%0d done=%b, required 1/0/0", we, waddr, done); bad++; end
    repeat (511) @(negedge clk);
    total++;
    if (waddr !== 15'd511 || pcnt !== 10'd65) begin $display("FAIL wrap_next_pkt: waddr=%0d pkt=%0d, required 511/65", waddr, pcnt); bad++; end
    rst = 1;
    @(negedge clk);
    rst = 0;
    total++;
    if ({we, waddr, busy, done, pcnt} !== '0) begin $display("FAIL reset_mid_capture: we=%b waddr=%0d busy=%b done=%b pkt=%0d, required all 0", we, waddr, busy, done, pcnt); bad++; end
  endtask
  task automatic test_abort;
    do_reset;
    path = 7'd1; start = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i <= 94; i++) begin
      valid = 1; data = 9'(i);
      if (i == 94) start = 0;
      @(negedge clk);
    end
    total++;
    if (we !== 1'b1 || waddr !== 15'd94 || wdata !== 9'd94) begin $display("FAIL abort_last_write: we=%b waddr=%0d wdata=%0d, required 1/94/94", we, waddr, wdata); bad++; end
    total++;
    if (busy !== 1'b0 || pcnt !== 10'd1) begin $display("FAIL abort_state: busy=%b pkt=%0d, required 0/1", busy, pcnt); bad++; end
    @(negedge clk);
    valid = 0;
    total++;
    if (we !== 1'b0 || pcnt !== 10'd1 || busy !== 1'b0) begin $display("FAIL abort_after: we=%b pkt=%0d busy=%b, required 0/1/0", we, pcnt, busy); bad++; end
  endtask
  initial begin
    test_reset;
    test_single_selftest_and_again;
    test_gap;
    test_paths;
    test_abort;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
